// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Holds the FSM state encoding, default parameter values and the counter width.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Both cycle parameters are capped at 255, so one counter width covers them.
  localparam int CNT_MAX = 255;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

endpackage

// File: rtl/sar_adc_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 cycles; no backpressure.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion sequencer: track/hold, MSB-first bit trials, result over valid/ready.
// Latency: SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES from start; result held until ready_i. SAR_DAC_PASSTHRU_EN adds the IDLE DAC write port.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SAR_DAC_PASSTHRU_EN
  input  logic [WIDTH-1:0] dac_i,
  input  logic             dac_we_i,
`endif
  input  logic             start_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hold_q;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             cmp_s;

  sync2 u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_i),
    .q     (cmp_s)
  );

`ifdef SAR_DAC_PASSTHRU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state_q == IDLE && dac_we_i) begin
      hold_q <= dac_i;
    end
  end
`else
  assign hold_q = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      result_q <= result_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SAMPLE;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          code_d   = '0;
          cnt_d    = CNT_W'(SAMPLE_CYCLES - 1);
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d            = CONVERT;
          sample_d           = 1'b0;
          bit_d              = BIT_W'(WIDTH - 1);
          code_d             = '0;
          code_d[WIDTH-1]    = 1'b1;
          cnt_d              = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // The trial bit is 1, so keeping-or-clearing it is just the decision itself.
          code_d[bit_q] = cmp_s;
          if (bit_q != '0) begin
            code_d[bit_q - BIT_W'(1)] = 1'b1;
            bit_d                     = bit_q - BIT_W'(1);
            cnt_d                     = CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            state_d  = DONE;
            result_d = code_d;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dac_code_o = (state_q == IDLE) ? hold_q : code_q;
  assign sample_o   = sample_q;
  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomized directed bench for sar_adc_ctrl against an ideal-comparator SAR model.
module tb_sar_adc_ctrl;

  localparam int W   = 8;
  localparam int SC  = 4;
  localparam int ST  = 4;
  localparam int LAT = SC + W * ST;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         cmp_i;
  logic         sample_o;
  logic [W-1:0] dac_code_o;
  logic         busy_o;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] vin;
`ifdef SAR_DAC_PASSTHRU_EN
  logic [W-1:0] dac_i;
  logic         dac_we_i;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SAR_DAC_PASSTHRU_EN
    .dac_i      (dac_i),
    .dac_we_i   (dac_we_i),
`endif
    .start_i    (start_i),
    .cmp_i      (cmp_i),
    .sample_o   (sample_o),
    .dac_code_o (dac_code_o),
    .busy_o     (busy_o),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  // Ideal analog side: comparator reports Vin >= Vdac.
  assign cmp_i = (vin >= dac_code_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Trial code for bit k: bits above k taken from Vin, bit k set, bits below clear.
  function automatic logic [31:0] trial_code(input int v, input int k);
    return ((v >> (k + 1)) << (k + 1)) | (1 << k);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, {31'd0, sample_o}, 0);
    check({tag, "_busy"},   {31'd0, busy_o},   0);
    check({tag, "_valid"},  {31'd0, valid_o},  0);
    check({tag, "_dac"},    {24'd0, dac_code_o}, 0);
    check({tag, "_result"}, {24'd0, result_o},   0);
  endtask

  task automatic run_conv(input logic [W-1:0] v, input int ready_delay, input int abort_cycle,
                          input bit pulse_busy, input logic [W-1:0] idle_exp);
    int cycles;
    bit seen;
    vin = v;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_sample", {31'd0, sample_o}, 1);
    check("start_busy",   {31'd0, busy_o},   1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == abort_cycle) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst_n   = 1'b1;
        start_i = 1'b0;
        return;
      end
      if (cycles < SC) begin
        check("track_sample", {31'd0, sample_o}, 1);
        check("track_valid",  {31'd0, valid_o},  0);
      end else if (cycles < LAT) begin
        check("trial_code", {24'd0, dac_code_o}, trial_code(v, W - 1 - (cycles - SC) / ST));
        check("conv_sample", {31'd0, sample_o}, 0);
        check("conv_busy",   {31'd0, busy_o},   1);
        check("conv_valid",  {31'd0, valid_o},  0);
      end else begin
        seen = valid_o;
      end
      start_i = pulse_busy && (cycles == 1 || cycles == 12);
`ifdef SAR_DAC_PASSTHRU_EN
      dac_we_i = pulse_busy && (cycles == 12);
      dac_i    = 8'h55;
`endif
    end
    check("latency", cycles, LAT);
    check("result", {24'd0, result_o}, {24'd0, v});
    for (int d = 0; d < ready_delay; d++) begin
      start_i = (d == 3);
      @(negedge clk);
      check("hold_valid",  {31'd0, valid_o},  1);
      check("hold_result", {24'd0, result_o}, {24'd0, v});
      check("hold_dac",    {24'd0, dac_code_o}, {24'd0, v});
      check("hold_busy",   {31'd0, busy_o},   0);
    end
    ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    start_i = 1'b0;
    check("ack_valid", {31'd0, valid_o}, 0);
    check("ack_dac",   {24'd0, dac_code_o}, {24'd0, idle_exp});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy",  {31'd0, busy_o},  0);
      check("idle_valid", {31'd0, valid_o}, 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    vin     = '0;
`ifdef SAR_DAC_PASSTHRU_EN
    dac_i    = '0;
    dac_we_i = 1'b0;
`endif
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_conv(8'hA5, 0, -1, 1'b0, 8'h00);
    run_conv(8'h00, 0, -1, 1'b0, 8'h00);
    run_conv(8'hFF, 0, -1, 1'b0, 8'h00);
    run_conv(8'h5A, 10, -1, 1'b0, 8'h00);
    run_conv(8'hA5, 0, SC + 4 * ST + 1, 1'b0, 8'h00);
    run_conv(8'h3C, 0, -1, 1'b0, 8'h00);
    run_conv(8'hC3, 2, -1, 1'b1, 8'h00);
    for (int r = 0; r < 6; r++) begin
      run_conv(W'($urandom_range(0, 255)), int'($urandom_range(0, 5)), -1,
               1'($urandom_range(0, 1)), 8'h00);
    end

`ifdef SAR_DAC_PASSTHRU_EN
    @(negedge clk);
    dac_i    = 8'h7E;
    dac_we_i = 1'b1;
    @(negedge clk);
    dac_we_i = 1'b0;
    check("passthru_write", {24'd0, dac_code_o}, 32'h7E);
    run_conv(8'h10, 1, -1, 1'b1, 8'h7E);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
